uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DATA_BITS, default 8: character width; legal range 5..8.
REQ-002 Parameter BAUD_DIV, default 103: CLKIN cycles per serial bit; legal range >= 2.
REQ-003 Parameter PARITY, default 0: parity mode; 0 = none, 1 = even, 2 = odd.
REQ-004 Parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-005 Parameter FIFO_DEPTH, default 16: transmit buffer entries; power of two, >= 2.
REQ-006 Port CLKIN, input, 1: the only clock; all state updates on its rising edge.
REQ-007 Port RESETN, input, 1: synchronous, active-low reset.
REQ-008 Port I, input, DATA_BITS: character to enqueue.
REQ-009 Port VALID, input, 1: I is presented for enqueue.
REQ-010 Port READY, output, 1: FIFO can accept a character this cycle.
REQ-011 Port TX, output, 1: serial line, registered, idle high.
REQ-012 Port BUSY, output, 1: a frame is in progress (state not IDLE).
REQ-013 Port COUNT, output, clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Function
REQ-014 A push SHALL occur on a cycle with VALID=1 and READY=1; the write stores I at the tail.
REQ-015 READY SHALL be 1 exactly when COUNT < FIFO_DEPTH and RESETN=1; a push is refused while full, even if a pop occurs in the same cycle.
REQ-016 The baud divider SHALL count 0..BAUD_DIV-1 and wrap, free-running from reset; a tick occurs on the cycle its value is BAUD_DIV-1.
REQ-017 FSM states: IDLE, START, DATA, PARITY, STOP; all transitions SHALL occur only on ticks.
REQ-018 IDLE, on a tick with COUNT>0: pop the head into the shift register and go to START; TX=0 from the next cycle.
REQ-019 START: after one bit period, go to DATA.
REQ-020 DATA: shift out DATA_BITS bits LSB first, one bit period each, then go to PARITY if PARITY!=0, else to STOP.
REQ-021 The even parity bit SHALL be the XOR of the data bits; the odd parity bit SHALL be its inverse.
REQ-022 STOP: hold TX=1 for STOP_BITS bit periods.
REQ-023 At the end of STOP, with COUNT>0: pop the next character and go directly to START, with no idle bit between frames.
REQ-024 At the end of STOP, with COUNT=0: go to IDLE, TX=1.
REQ-025 Every TX level SHALL last exactly BAUD_DIV cycles.
REQ-026 A push and a pop in the same cycle SHALL leave COUNT unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 COUNT SHALL never exceed FIFO_DEPTH and never underflow.

Reset
REQ-029 While RESETN=0 at a clock edge, the following SHALL be set:
- divider = 0
- FIFO empty (COUNT=0)
- state = IDLE
- TX = 1
- BUSY = 0
- READY = 0
REQ-030 Reset mid-frame SHALL abandon the frame and drive TX=1 from the next edge; buffered characters are discarded.
REQ-031 The first tick after release SHALL occur BAUD_DIV cycles after the first edge with RESETN=1.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state type and the parity-mode constants PAR_NONE, PAR_EVEN and PAR_ODD.
REQ-033 The FIFO SHALL be a separate sub-module, uart_fifo, parameterised by width and depth, providing push, pop, full, empty and count.
REQ-034 The top level contains the divider, FSM, shift register and parity logic.

Verification
REQ-035 BAUD_DIV=4, 8N1; push 0x48. Required: TX = 0,0,0,0,1,0,0,1,0,1, each level held 4 cycles; BUSY high for 40 cycles.
REQ-036 PARITY=1 and PARITY=2; push 0x48. Required: parity bit 0 (even) and 1 (odd), placed after bit 7; frame lasts 11 bit periods.
REQ-037 DATA_BITS=7, STOP_BITS=2, PARITY=0; push 0x7F. Required: start, seven 1s, then 2 stop periods = 10 bit periods; the unused upper bit is never transmitted.
REQ-038 BAUD_DIV=103, FIFO_DEPTH=16; hold VALID=1 for 20 bytes "Hello, world! \r\n.." from reset release. Required: 16 pushes accepted, then READY=0 until the first pop at cycle 103; all 20 frames sent contiguously with no idle gap.
REQ-039 Assert RESETN=0 during DATA of the second of 3 queued frames. Required: TX=1 and COUNT=0 on the next edge; after release, no frame is sent until a new push.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    // Frame sequencer states; S_PARITY is skipped when no parity is configured.
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Turns the XOR-reduction of the data bits into the transmitted parity bit.
    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == PAR_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Circular character buffer with show-ahead head and occupancy count.
// Latency: a pushed entry is visible at head on the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             core_clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Full is judged on the current count, so a same-cycle pop never frees room for a push.
    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge core_clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy is tracked by count.
    always_ff @(posedge core_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO, free-running baud divider, frame FSM, TX register.
// Latency: first frame starts on the next baud tick after a character is buffered.
// Backpressure: READY drops while the FIFO is full or reset is asserted.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 103,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          CLKIN,
    input  logic                          RESETN,
    input  logic [DATA_BITS-1:0]          I,
    input  logic                          VALID,
    output logic                          READY,
    output logic                          TX,
    output logic                          BUSY,
    output logic [$clog2(FIFO_DEPTH):0]   COUNT
);

    localparam int DIV_W = $clog2(BAUD_DIV);

    logic [DIV_W-1:0]     div;
    logic                 tick;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 pop;
    logic                 push;

    state_t               state,    state_n;
    logic [DATA_BITS-1:0] shift,    shift_n;
    logic [2:0]           bit_cnt,  bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 par,      par_n;
    logic                 tx,       tx_n;
    logic                 load;

    assign tick  = (div == DIV_W'(BAUD_DIV - 1));
    assign READY = !fifo_full && RESETN;
    assign push  = VALID && READY;
    assign TX    = tx;
    assign BUSY  = (state != S_IDLE);

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .core_clk  (CLKIN),
        .rst_n     (RESETN),
        .push      (push),
        .push_data (I),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (COUNT)
    );

    // Baud divider: free-running 0..BAUD_DIV-1, restarted only by reset.
    always_ff @(posedge CLKIN) begin
        if (!RESETN)   div <= '0;
        else if (tick) div <= '0;
        else           div <= div + DIV_W'(1);
    end

    // Frame state and registered serial line; reset abandons any frame in flight.
    always_ff @(posedge CLKIN) begin
        if (!RESETN) begin
            state    <= S_IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par      <= 1'b0;
            tx       <= 1'b1;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            par      <= par_n;
            tx       <= tx_n;
        end
    end

    // Next-state logic: everything moves on a tick; the TX level for the coming
    // bit period is chosen together with the state it belongs to.
    always_comb begin
        state_n    = state;
        shift_n    = shift;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        par_n      = par;
        tx_n       = tx;
        load       = 1'b0;
        pop        = 1'b0;
        if (tick) begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) load = 1'b1;
                end
                S_START: begin
                    state_n   = S_DATA;
                    bit_cnt_n = '0;
                    tx_n      = shift[0];
                end
                S_DATA: begin
                    if (bit_cnt == 3'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state_n = S_PARITY;
                            tx_n    = par;
                        end else begin
                            state_n    = S_STOP;
                            stop_cnt_n = 1'b0;
                            tx_n       = 1'b1;
                        end
                    end else begin
                        shift_n   = shift >> 1;
                        bit_cnt_n = bit_cnt + 3'd1;
                        tx_n      = shift[1];
                    end
                end
                S_PARITY: begin
                    state_n    = S_STOP;
                    stop_cnt_n = 1'b0;
                    tx_n       = 1'b1;
                end
                S_STOP: begin
                    if (stop_cnt == 1'(STOP_BITS - 1)) begin
                        // Back-to-back frames: no idle bit when more data is queued.
                        if (!fifo_empty) begin
                            load = 1'b1;
                        end else begin
                            state_n = S_IDLE;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        stop_cnt_n = 1'b1;
                    end
                end
                default: begin
                    state_n = S_IDLE;
                    tx_n    = 1'b1;
                end
            endcase
            if (load) begin
                pop     = 1'b1;
                shift_n = fifo_head;
                par_n   = parity_bit(^fifo_head, PARITY);
                state_n = S_START;
                tx_n    = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: several configurations run in parallel against a queue-based line model.
// Latency: n/a.
// Backpressure: stimulus obeys the model's view of READY.
module tb_uart_tx_fifo;

    localparam int NCFG = 5;
    localparam int CFG_DB    [NCFG] = '{8, 8, 8, 7, 8};
    localparam int CFG_B     [NCFG] = '{4, 4, 5, 3, 103};
    localparam int CFG_P     [NCFG] = '{0, 1, 2, 0, 0};
    localparam int CFG_S     [NCFG] = '{1, 1, 1, 2, 1};
    localparam int CFG_D     [NCFG] = '{4, 4, 8, 2, 16};
    localparam int CFG_LEN   [NCFG] = '{10, 11, 11, 10, 10};
    localparam int CFG_LIT   [NCFG] = '{32'h290, 32'h490, 32'h690, 32'h3FE, 32'h0};
    localparam int CFG_CH    [NCFG] = '{32'h48, 32'h48, 32'h48, 32'h7F, 32'h0};
    localparam int CFG_SCRIPT[NCFG] = '{0, 1, 1, 1, 2};

    logic clk;
    int   ncyc  = 0;
    int   total = 0;
    int   bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ncyc <= ncyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, ncyc);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : inst
        localparam int DB     = CFG_DB[g];
        localparam int B      = CFG_B[g];
        localparam int P      = CFG_P[g];
        localparam int S      = CFG_S[g];
        localparam int DP     = CFG_D[g];
        localparam int LEN    = CFG_LEN[g];
        localparam int SCRIPT = CFG_SCRIPT[g];

        logic                   rst_n_i;
        logic                   valid_i;
        logic [DB-1:0]          dat_i;
        logic                   ready_o;
        logic                   tx_o;
        logic                   busy_o;
        logic [$clog2(DP):0]    count_o;

        uart_tx_fifo #(
            .DATA_BITS  (DB),
            .BAUD_DIV   (B),
            .PARITY     (P),
            .STOP_BITS  (S),
            .FIFO_DEPTH (DP)
        ) dut (
            .CLKIN  (clk),
            .RESETN (rst_n_i),
            .I      (dat_i),
            .VALID  (valid_i),
            .READY  (ready_o),
            .TX     (tx_o),
            .BUSY   (busy_o),
            .COUNT  (count_o)
        );

        // Model: buffered characters, remaining line levels of the frame in flight.
        int    mq[$];
        int    lv[$];
        int    m_tx;
        int    m_busy;
        int    m_cyc;
        bit    cur_rst;
        int    idx;
        string msg;

        initial begin
            rst_n_i = 1'b0;
            valid_i = 1'b0;
            dat_i   = '0;
            m_tx    = 1;
            m_busy  = 0;
            m_cyc   = 0;
            cur_rst = 1'b0;
            idx     = 0;
            msg     = "Hello, world! \\r\\n..";
        end

        always @(negedge clk) begin
            automatic bit nr   = 1'b1;
            automatic bit nv   = 1'b0;
            automatic int nd   = int'($urandom_range(0, (1 << DB) - 1));
            automatic int dens;
            automatic int c;

            check($sformatf("g%0d tx", g),    int'(tx_o),    m_tx);
            check($sformatf("g%0d busy", g),  int'(busy_o),  m_busy);
            check($sformatf("g%0d count", g), int'(count_o), mq.size());
            check($sformatf("g%0d ready", g), int'(ready_o), int'(cur_rst && (mq.size() < DP)));

            if (ncyc <= 3) begin
                nr = 1'b0;
            end else if (SCRIPT == 2) begin
                if (idx < 20) begin
                    nv = 1'b1;
                    nd = int'(msg[idx]);
                    if (mq.size() < DP) idx++;
                end
            end else if (ncyc == 4) begin
                nv = 1'b1;
                nd = CFG_CH[g];
            end else if (SCRIPT == 0 && ncyc < 260) begin
                if (ncyc == 100 || ncyc == 101 || ncyc == 160 || ncyc == 161) nr = 1'b0;
                else if (ncyc >= 102 && ncyc <= 104) nv = 1'b1;
            end else if (ncyc > 80) begin
                if ($urandom_range(0, 299) == 0) nr = 1'b0;
                dens = ((ncyc / 400) % 2 == 1) ? 85 : 4;
                nv   = ($urandom_range(0, 99) < dens);
            end

            rst_n_i = nr;
            valid_i = nv;
            dat_i   = DB'(nd);
            cur_rst = nr;

            if (!nr) begin
                mq.delete();
                lv.delete();
                m_tx   = 1;
                m_busy = 0;
                m_cyc  = 0;
            end else begin
                automatic bit push = nv && (mq.size() < DP);
                if (m_cyc % B == B - 1) begin
                    if (lv.size() > 0) begin
                        m_tx = lv.pop_front();
                    end else if (mq.size() > 0) begin
                        c = mq.pop_front();
                        lv.push_back(0);
                        for (int i = 0; i < DB; i++) lv.push_back((c >> i) & 1);
                        if (P != 0) lv.push_back(($countones(c) % 2) ^ int'(P == 2));
                        for (int s = 0; s < S; s++) lv.push_back(1);
                        m_tx   = lv.pop_front();
                        m_busy = 1;
                    end else begin
                        m_tx   = 1;
                        m_busy = 0;
                    end
                end
                m_cyc++;
                if (push) mq.push_back(nd);
            end
        end

        // Hand-computed frames for the single character pushed right after reset.
        if (g < 4) begin : frame_chk
            int         txs[$];
            logic [10:0] litv;
            initial litv = 11'(CFG_LIT[g]);
            always @(negedge clk) begin
                if (ncyc >= 4 && ncyc < 80 && busy_o) txs.push_back(int'(tx_o));
                if (ncyc == 80) begin
                    check($sformatf("g%0d frame_len", g), txs.size(), LEN * B);
                    for (int k = 0; k < LEN; k++) begin
                        automatic int hits = 0;
                        for (int j = 0; j < B; j++)
                            if (k * B + j < txs.size() && txs[k * B + j] == int'(litv[k])) hits++;
                        check($sformatf("g%0d frame_bit%0d", g, k), hits, B);
                    end
                end
            end
        end

        // Reset during DATA of the second of three queued frames.
        if (g == 0) begin : rst_chk
            int viol = 0;
            always @(negedge clk) begin
                if (ncyc == 161) begin
                    check("g0 rst_tx", int'(tx_o), 1);
                    check("g0 rst_count", int'(count_o), 0);
                end
                if (ncyc >= 163 && ncyc < 260 && (busy_o || !tx_o)) viol++;
                if (ncyc == 260) check("g0 quiet_after_reset", viol, 0);
            end
        end

        // Twenty-character burst held from reset release at BAUD_DIV=103.
        if (g == 4) begin : stream_chk
            int bcnt = 0;
            int runs = 0;
            bit prev = 1'b0;
            always @(negedge clk) begin
                if (busy_o) bcnt++;
                if (busy_o && !prev) runs++;
                prev = busy_o;
                if (ncyc == 20) begin
                    check("g4 count_full", int'(count_o), 16);
                    check("g4 ready_full", int'(ready_o), 0);
                end
                if (ncyc == 106) check("g4 busy_before_tick", int'(busy_o), 0);
                if (ncyc == 107) check("g4 busy_first_tick", int'(busy_o), 1);
                if (ncyc == 21000) begin
                    check("g4 busy_cycles", bcnt, 20600);
                    check("g4 busy_runs", runs, 1);
                end
            end
        end
    end

    initial begin
        repeat (21100) @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
